// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions for the BPSK link: sequence length, taps, seed and BER FSM states.
package prbs_pkg;

    localparam int unsigned PRBS9_LEN    = 511;
    localparam int unsigned PRBS9_TAP_HI = 8;   // x^9
    localparam int unsigned PRBS9_TAP_LO = 4;   // x^5
    localparam logic [8:0]  PRBS9_SEED_DEFAULT = 9'h1AA;

    typedef enum logic {
        ALIGN  = 1'b0,
        LOCKED = 1'b1
    } ber_state_e;

    // Fibonacci step for x^9+x^5+1; the output bit is the MSB before the step.
    function automatic logic [8:0] prbs9_next(input logic [8:0] s);
        return {s[7:0], s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs9_ref.sv
// PRBS9 reference: LFSR plus delay-indexed history; delay 0 reads the current LFSR output.
module prbs9_ref
    import prbs_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_SEED_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_advance,
    input  logic [8:0] i_delay,
    output logic       o_ref
);

    logic [8:0]           lfsr_q;
    logic [8:0]           lfsr_d;
    logic [PRBS9_LEN-2:0] hist_q;
    logic [PRBS9_LEN-2:0] hist_d;
    logic [PRBS9_LEN-1:0] window;

    always_comb begin
        lfsr_d = lfsr_q;
        hist_d = hist_q;
        if (i_advance) begin
            lfsr_d = prbs9_next(lfsr_q);
            hist_d = {hist_q[PRBS9_LEN-3:0], lfsr_q[PRBS9_TAP_HI]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
            hist_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            hist_q <= hist_d;
        end
    end

    // The 511-entry window is the live output followed by the 510 previous outputs.
    assign window = {hist_q, lfsr_q[PRBS9_TAP_HI]};
    assign o_ref  = window[i_delay];

endmodule

// File: rtl/rx_ber_checker.sv
// BPSK decimator/slicer with PRBS9 delay search and BER counting.
// Optional macro RX_BER_RELOCK_EN: relock when a locked window exceeds RELOCK_TH errors.
module rx_ber_checker
    import prbs_pkg::*;
#(
    parameter int unsigned OS        = 4,
    parameter int unsigned NB_DATA   = 8,
    parameter logic [8:0]  SEED      = PRBS9_SEED_DEFAULT,
    parameter int unsigned NB_CNT    = 32,
    parameter int unsigned RELOCK_TH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic [$clog2(OS)-1:0] i_phase,
    input  logic [NB_DATA-1:0]    i_sample,
    output logic                  o_bit,
    output logic                  o_bit_valid,
    output logic                  o_locked,
    output logic [8:0]            o_delay,
    output logic [NB_CNT-1:0]     o_err_cnt,
    output logic [NB_CNT-1:0]     o_bit_cnt,
    output logic                  o_ber_zero
);

    localparam int unsigned NB_PC = $clog2(OS);
`ifdef RX_BER_RELOCK_EN
    localparam bit RELOCK_EN = 1'b1;
`else
    localparam bit RELOCK_EN = 1'b0;
`endif

    ber_state_e        state_q, state_d;
    logic [NB_PC-1:0]  pc_q;
    logic [8:0]        wc_q, wc_d;
    logic [8:0]        we_q, we_d;
    logic [8:0]        delay_q, delay_d;
    logic [NB_CNT-1:0] err_q, err_d;
    logic [NB_CNT-1:0] bitc_q, bitc_d;
    logic              bit_q, valid_q;

    logic       strobe;
    logic       bit_now;
    logic       ref_bit;
    logic       mismatch;
    logic       window_end;
    logic [8:0] we_sum;
    logic [8:0] delay_inc;

    assign strobe     = i_enable && (pc_q == i_phase);
    assign bit_now    = ~i_sample[NB_DATA-1];
    assign mismatch   = bit_now ^ ref_bit;
    assign window_end = (wc_q == 9'(PRBS9_LEN - 1));
    assign we_sum     = (we_q == '1) ? we_q : we_q + {8'd0, mismatch};
    assign delay_inc  = (delay_q == 9'(PRBS9_LEN - 1)) ? '0 : delay_q + 9'd1;

    prbs9_ref #(.SEED(SEED)) u_ref (
        .clock     (clock),
        .reset     (reset),
        .i_advance (strobe),
        .i_delay   (delay_q),
        .o_ref     (ref_bit)
    );

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        we_d    = we_q;
        delay_d = delay_q;
        err_d   = err_q;
        bitc_d  = bitc_q;
        if (strobe) begin
            unique case (state_q)
                ALIGN: begin
                    wc_d = window_end ? '0 : wc_q + 9'd1;
                    we_d = window_end ? '0 : we_sum;
                    if (window_end) begin
                        if (we_sum == '0) begin
                            state_d = LOCKED;
                            err_d   = '0;
                            bitc_d  = '0;
                        end else begin
                            delay_d = delay_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (bitc_q != '1) begin
                        bitc_d = bitc_q + NB_CNT'(1);
                        err_d  = err_q + NB_CNT'(mismatch);
                    end
                    if (RELOCK_EN) begin
                        wc_d = window_end ? '0 : wc_q + 9'd1;
                        we_d = window_end ? '0 : we_sum;
                        if (window_end && ({23'd0, we_sum} > RELOCK_TH)) begin
                            state_d = ALIGN;
                            delay_d = delay_inc;
                            err_d   = '0;
                            bitc_d  = '0;
                        end
                    end
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ALIGN;
            pc_q    <= '0;
            wc_q    <= '0;
            we_q    <= '0;
            delay_q <= '0;
            err_q   <= '0;
            bitc_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            delay_q <= delay_d;
            err_q   <= err_d;
            bitc_q  <= bitc_d;
            valid_q <= strobe;
            // OS is a power of two, so the phase counter wraps naturally.
            if (i_enable) pc_q <= pc_q + NB_PC'(1);
            if (strobe)   bit_q <= bit_now;
        end
    end

    assign o_bit       = bit_q;
    assign o_bit_valid = valid_q;
    assign o_locked    = (state_q == LOCKED);
    assign o_delay     = delay_q;
    assign o_err_cnt   = err_q;
    assign o_bit_cnt   = bitc_q;
    assign o_ber_zero  = (state_q == LOCKED) && (err_q == '0);

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed bench for rx_ber_checker: TX PRBS9 through a 5-symbol channel delay at OS=4.
module tb_rx_ber_checker;

    localparam int unsigned OS       = 4;
    localparam int unsigned CH_DELAY = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [1:0]  i_phase;
    logic [7:0]  i_sample;
    logic        o_bit, o_bit_valid, o_locked, o_ber_zero;
    logic [8:0]  o_delay;
    logic [31:0] o_err_cnt, o_bit_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        txbits [0:510];
    int unsigned sym_n = 0;
    int unsigned flip_period = 0;
    int unsigned flip_ctr = 0;
    logic        split = 1'b0;

    rx_ber_checker #(
        .OS(OS), .NB_DATA(8), .SEED(9'h1AA), .NB_CNT(32), .RELOCK_TH(64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (i_enable),
        .i_phase     (i_phase),
        .i_sample    (i_sample),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_locked    (o_locked),
        .o_delay     (o_delay),
        .o_err_cnt   (o_err_cnt),
        .o_bit_cnt   (o_bit_cnt),
        .o_ber_zero  (o_ber_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Received symbol n: a few hand-picked values before the delayed PRBS arrives.
    function automatic logic [7:0] sym_val(input int unsigned n);
        logic b;
        if (n == 2) return 8'd0;
        if (n < CH_DELAY) b = (n != 1);
        else              b = txbits[(n - CH_DELAY) % 511];
        return b ? 8'd64 : 8'hC0;
    endfunction

    task automatic send_sym(input logic [7:0] v, input bit chk_first);
        for (int unsigned p = 0; p < OS; p++) begin
            if (split && p != 2) i_sample = v[7] ? 8'd64 : 8'hC0;
            else                 i_sample = v;
            @(posedge clock); #1;
            if (chk_first && p == 0) check("strobe_after_resume", o_bit_valid, 1'b1);
        end
    endtask

    task automatic send_n(input int unsigned count);
        logic [7:0] v;
        for (int unsigned k = 0; k < count; k++) begin
            v = sym_val(sym_n);
            if (flip_period != 0) begin
                flip_ctr++;
                if (flip_ctr % flip_period == 0) v = v[7] ? 8'd64 : 8'hC0;
            end
            send_sym(v, 1'b0);
            sym_n++;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sym_n = 0;
    endtask

    initial begin
        logic [8:0] s;
        logic       exp_bit [0:2];
        s = 9'h1AA;
        for (int i = 0; i < 511; i++) begin
            txbits[i] = s[8];
            s = {s[7:0], s[8] ^ s[4]};
        end
        exp_bit[0] = 1'b1; exp_bit[1] = 1'b0; exp_bit[2] = 1'b1;

        reset = 1'b1; i_enable = 1'b0; i_phase = 2'd0; i_sample = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_bit",    o_bit,       1'b0);
        check("rst_valid",  o_bit_valid, 1'b0);
        check("rst_locked", o_locked,    1'b0);
        check("rst_delay",  o_delay,     9'd0);
        check("rst_err",    o_err_cnt,   32'd0);
        check("rst_bits",   o_bit_cnt,   32'd0);
        check("rst_berz",   o_ber_zero,  1'b0);

        // Released but disabled: nothing moves.
        reset = 1'b0;
        i_sample = 8'hC0;
        repeat (10) @(posedge clock);
        #1;
        check("dis_valid", o_bit_valid, 1'b0);
        check("dis_bit",   o_bit,       1'b0);
        check("dis_delay", o_delay,     9'd0);

        // First symbols: registered slicer output and one-cycle strobe.
        i_enable = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            i_sample = sym_val(k);
            @(posedge clock); #1;
            check("sym_valid", o_bit_valid, 1'b1);
            check("sym_bit",   o_bit,       exp_bit[k]);
            @(posedge clock); #1;
            check("sym_valid_drop", o_bit_valid, 1'b0);
            repeat (OS - 2) @(posedge clock);
            #1;
        end
        sym_n = 3;
        send_n(97);

        // Odd-length pause: the phase counter must not slip.
        i_enable = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        check("pause_valid", o_bit_valid, 1'b0);
        i_enable = 1'b1;
        send_sym(sym_val(sym_n), 1'b1);
        sym_n++;

        send_n(3065 - sym_n);
        check("prelock_locked", o_locked, 1'b0);
        check("prelock_delay",  o_delay,  9'd5);
        send_n(1);
        check("lock_locked", o_locked,   1'b1);
        check("lock_delay",  o_delay,    9'd5);
        check("lock_bits",   o_bit_cnt,  32'd0);
        check("lock_berz",   o_ber_zero, 1'b1);

        send_n(1000);
        check("clean_bits", o_bit_cnt,  32'd1000);
        check("clean_err",  o_err_cnt,  32'd0);
        check("clean_berz", o_ber_zero, 1'b1);

        flip_period = 100; flip_ctr = 0;
        send_n(1000);
        check("flip_bits",   o_bit_cnt,  32'd2000);
        check("flip_err",    o_err_cnt,  32'd10);
        check("flip_berz",   o_ber_zero, 1'b0);
        check("flip_locked", o_locked,   1'b1);
        flip_period = 0;

        // Asynchronous reset while locked.
        reset = 1'b1;
        #1;
        check("mid_rst_locked", o_locked,  1'b0);
        check("mid_rst_err",    o_err_cnt, 32'd0);
        check("mid_rst_bits",   o_bit_cnt, 32'd0);
        check("mid_rst_delay",  o_delay,   9'd0);
        @(posedge clock); #1;
        check("mid_rst_berz",  o_ber_zero,  1'b0);
        check("mid_rst_valid", o_bit_valid, 1'b0);
        reset = 1'b0;
        sym_n = 0;
        send_n(3066);
        check("relock_locked", o_locked,  1'b1);
        check("relock_delay",  o_delay,   9'd5);
        check("relock_err",    o_err_cnt, 32'd0);

        // Waveform valid only at phase 2; phase 0 sees the complement and never locks.
        split = 1'b1;
        i_phase = 2'd0;
        pulse_reset();
        send_n(7 * 511);
        check("ph0_locked", o_locked, 1'b0);
        check("ph0_delay",  o_delay,  9'd7);

        i_phase = 2'd2;
        pulse_reset();
        send_n(3065);
        check("ph2_prelock", o_locked, 1'b0);
        send_n(1);
        check("ph2_locked", o_locked, 1'b1);
        check("ph2_delay",  o_delay,  9'd5);
        send_n(10);
        check("ph2_bits", o_bit_cnt, 32'd10);
        check("ph2_err",  o_err_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
